// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the multi-cycle shifter.
// Optional rotate support is selected by SHIFT_UNIT_ROTATE_EN in the users of this package.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int STEP_DEF  = 4;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a WIDTH word by amt bits in the given mode.
// Rotate right exists only when SHIFT_UNIT_ROTATE_EN is defined; otherwise mode 11 passes through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  mode_e            mode,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = data;
    case (mode)
      MODE_SLL: res = data << amt;
      MODE_SRL: res = data >> amt;
      // Repeated arithmetic steps keep the sign bit, so every step replicates the original MSB.
      MODE_SRA: res = $unsigned($signed(data) >>> amt);
`ifdef SHIFT_UNIT_ROTATE_EN
      MODE_ROTR: res = (data >> amt) | (data << (WIDTH - int'(amt)));
`else
      MODE_ROTR: res = data;
`endif
      default: res = data;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: IDLE->BUSY->DONE FSM moving up to STEP bits per cycle, valid/ready on both sides.
// Define SHIFT_UNIT_ROTATE_EN to make mode 11 a rotate right; otherwise mode 11 is a 1-cycle pass-through.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int STEP    = STEP_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         mode_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               busy_o
);

  state_e             state, next;
  mode_e              mode;
  logic [WIDTH-1:0]   work, step_res, res;
  logic [SHAMT_W-1:0] rem, n;
  logic               pass, accept, direct, last;

`ifdef SHIFT_UNIT_ROTATE_EN
  assign pass = 1'b0;
`else
  assign pass = (mode_e'(mode_i) == MODE_ROTR);
`endif

  assign accept = (state == ST_IDLE) && in_valid_i;
  assign direct = (shamt_i == '0) || pass;

  // Widened compare so STEP == WIDTH never overflows the amount width.
  always_comb begin
    if ({1'b0, rem} > (SHAMT_W+1)'(STEP)) n = SHAMT_W'(STEP);
    else                                   n = rem;
  end

  assign last = (rem == n);

  shift_step #(.WIDTH(WIDTH), .AMT_W(SHAMT_W)) u_step (
    .data (work),
    .amt  (n),
    .mode (mode),
    .res  (step_res)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (in_valid_i) next = direct ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last)       next = ST_DONE;
      ST_DONE: if (out_ready_i) next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == ST_IDLE);
    out_valid_o = (state == ST_DONE);
    busy_o      = (state == ST_BUSY) || (state == ST_DONE);
    data_o      = res;
  end

  // res only moves on entry to DONE, so the output survives the return to IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      work <= '0;
      rem  <= '0;
      mode <= MODE_SLL;
      res  <= '0;
    end else if (accept) begin
      work <= data_i;
      rem  <= pass ? '0 : shamt_i;
      mode <= mode_e'(mode_i);
      if (direct) res <= data_i;
    end else if (state == ST_BUSY) begin
      work <= step_res;
      rem  <= rem - n;
      if (last) res <= step_res;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=32, STEP=4): vector table plus reset/backpressure sequences.
// Mode 11 expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data_in),
    .shamt_i     (shamt),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_out),
    .busy_o      (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  // Issues one request and returns result and accept-edge-to-valid latency.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                        output logic [31:0] r, output int lat);
    wait_idle();
    data_in  = d;
    shamt    = s;
    mode     = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    r = data_out;
  endtask

  initial begin
    logic [31:0] r;
    int          lat;

    vecs[0]  = '{32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004, 2};
    vecs[1]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 9};
    vecs[2]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 9};
    vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 1};
    vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 1};
    vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1};
    vecs[7]  = '{32'h7000_0000, 5'd5,  2'b10, 32'h0380_0000, 3};
    vecs[8]  = '{32'hF000_00F0, 5'd4,  2'b10, 32'hFF00_000F, 2};
    vecs[9]  = '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800, 3};
    vecs[10] = '{32'h1234_5678, 5'd12, 2'b01, 32'h0001_2345, 4};
    vecs[11] = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 9};
`ifdef SHIFT_UNIT_ROTATE_EN
    vecs[12] = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 2};
    vecs[13] = '{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 3};
    vecs[14] = '{32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003, 9};
`else
    vecs[12] = '{32'h0000_0001, 5'd1,  2'b11, 32'h0000_0001, 1};
    vecs[13] = '{32'h1234_5678, 5'd8,  2'b11, 32'h1234_5678, 1};
    vecs[14] = '{32'h8000_0001, 5'd31, 2'b11, 32'h8000_0001, 1};
`endif

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", data_out, 32'h0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].data, vecs[i].shamt, vecs[i].mode, r, lat);
      check($sformatf("vec%0d_data", i), r, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result and valid hold, new requests ignored
    tick();
    out_ready = 1'b0;
    run_op(32'h0000_0001, 5'd8, 2'b00, r, lat);
    check("bp_data", r, 32'h0000_0100);
    check("bp_lat", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      data_in  = 32'hA5A5_0000 + 32'(k);
      shamt    = 5'd3;
      in_valid = k[0];
      tick();
      check($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", k), data_out, 32'h0000_0100);
      check($sformatf("bp_hold_busy%0d", k), 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_retain_data", data_out, 32'h0000_0100);
    tick();
    check("bp_idle_no_accept", 32'(busy), 32'd0);

    // Reset mid-BUSY aborts the operation
    wait_idle();
    data_in  = 32'h8000_0000;
    shamt    = 5'd31;
    mode     = 2'b10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midbusy_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", data_out, 32'h0);
    rst = 1'b1;
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) lat++;
    end
    check("midrst_no_result", 32'(lat), 32'd0);

    // Latency after abort still correct
    run_op(32'h0000_0003, 5'd1, 2'b01, r, lat);
    check("post_rst_data", r, 32'h0000_0001);
    check("post_rst_lat", 32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
